onehot_ring_fsm: RTL and testbench
==================================

ONEHOT_RING_FSM -- requirements
Module: onehot_ring_fsm

Interface
REQ-001 The block SHALL have parameter NUM_STATES, default 7, the number of ring states (legal range 2..32).
REQ-002 The block SHALL have parameter OUT_MASK [NUM_STATES-1:0], default {1'b1, (NUM_STATES-2)'b0, 1'b1}, the set of states that assert out.
REQ-003 The block SHALL have derived localparam IW = max(1, $clog2(NUM_STATES)), the width of the state index.
REQ-004 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-005 The block SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-006 The block SHALL have port x, input, 1, advance request, sampled each clk edge.
REQ-007 The block SHALL have port dir, input, 1, step direction (0 = index+1, 1 = index-1).
REQ-008 The block SHALL have port load, input, 1, synchronous load strobe.
REQ-009 The block SHALL have port load_idx, input, IW, the target state index for load.
REQ-010 The block SHALL have port out, output, 1, asserted while OUT_MASK[current index] = 1.
REQ-011 The block SHALL have port state_oh, output, NUM_STATES, the one-hot state register.
REQ-012 The block SHALL have port state_idx, output, IW, the binary index of the current state.
REQ-013 The block SHALL have port wrap, output, 1, a registered one-cycle pulse following a ring wrap.
REQ-014 The block SHALL have port err, output, 1, a registered one-cycle pulse flagging a bad load or illegal state.

Function
REQ-015 The state register SHALL be one-hot; state k SHALL be state_oh = 1<<k.
REQ-016 Next-state priority SHALL be: rst, then load, then x, then hold.
REQ-017 With load=1 and load_idx < NUM_STATES, state SHALL become load_idx at the next edge, regardless of x and dir.
REQ-018 With load=1 and load_idx >= NUM_STATES, state SHALL hold and err SHALL pulse the next cycle.
REQ-019 With load=0, x=1, dir=0, index k SHALL advance to (k+1) mod NUM_STATES.
REQ-020 With load=0, x=1, dir=1, index k SHALL go to (k-1) mod NUM_STATES, so 0 goes to NUM_STATES-1.
REQ-021 With load=0 and x=0, state SHALL hold.
REQ-022 wrap SHALL be 1 in the cycle after an x-step from NUM_STATES-1 to 0 (dir=0) or from 0 to NUM_STATES-1 (dir=1), else 0; a load SHALL never cause wrap.
REQ-023 out and state_idx SHALL be combinational from the state register only (Moore), with zero-cycle latency after a state change.
REQ-024 Consecutive x=1 cycles SHALL step once per cycle, with no bubbles.

Reset
REQ-025 While rst=1 at a clk edge: state_oh=1 (index 0), wrap=0, err=0; rst SHALL override load and x in the same cycle.
REQ-026 After reset, out SHALL equal OUT_MASK[0] (1 with the default OUT_MASK).
REQ-027 Reset asserted mid-sequence SHALL return to index 0 at that edge, with no wrap pulse.

Configuration
REQ-028 Macro ONEHOT_RING_ERRCHK_EN SHALL control the error-check logic.
REQ-029 With ONEHOT_RING_ERRCHK_EN defined: a state_oh that is not exactly one-hot SHALL force index 0 at the next edge and pulse err; this SHALL take priority over load and x, but not over rst.
REQ-030 With ONEHOT_RING_ERRCHK_EN defined: the bad-load err of REQ-018 SHALL be active.
REQ-031 With ONEHOT_RING_ERRCHK_EN undefined: err SHALL be tied 0 and no illegal-state recovery logic SHALL be generated; REQ-018 hold behaviour SHALL still apply.

Verification
REQ-032 Scenario, default params: rst, then x=1, dir=0 for 7 cycles; required response: index 0,1,...,6,0; out=1 at indices 0 and 6 only; wrap=1 exactly one cycle, after 6->0.
REQ-033 Scenario: at index 0, x=1, dir=1 for 2 cycles; required response: index 6 then 5; wrap pulses once, after 0->6.
REQ-034 Scenario: at index 2, load=1, load_idx=5, x=1; required response: index 5 next cycle, no wrap. Then load_idx=7; required response: index holds 5, err=1 for one cycle (macro defined).
REQ-035 Scenario: x held 0 for 10 cycles at index 3; required response: index 3 throughout, out=0, wrap=0.
REQ-036 Scenario: at index 4, rst=1, load=1, x=1 in the same cycle; required response: index 0, wrap=0, err=0.
REQ-037 Scenario, macro defined: force state_oh=7'b0000110 for one cycle; required response: next index 0, err=1 for one cycle.
REQ-038 Scenario, NUM_STATES=2 and NUM_STATES=32: run one full up-ring and one full down-ring; required response: one wrap pulse per ring in each direction.

Source files
------------

// File: rtl/onehot_ring_fsm.sv
// onehot_ring_fsm: a ring of NUM_STATES states held in a one-hot register.
// Each cycle the ring steps forward or backward on request, or jumps
// straight to a state on a load strobe.
// The optional macro ONEHOT_RING_ERRCHK_EN adds two things: an err pulse
// when a load names a state outside the ring, and recovery from a
// register that is not exactly one-hot.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (forces index 0)
//   x          advance request
//   dir        step direction: 0 = index+1, 1 = index-1
//   load       load strobe; has priority over x
//   load_idx   target index for load
//   out        Moore output, OUT_MASK[current index] (combinational)
//   state_oh   one-hot state register
//   state_idx  binary index of the current state (combinational)
//   wrap       registered pulse after an x-step across the ring seam
//   err        registered pulse on a bad load or an illegal state (macro only)
module onehot_ring_fsm #(
  parameter int unsigned           NUM_STATES = 7,
  parameter logic [NUM_STATES-1:0] OUT_MASK   =
    NUM_STATES'(1) | (NUM_STATES'(1) << (NUM_STATES - 1)),
  localparam int unsigned          IW = ($clog2(NUM_STATES) > 1) ? $clog2(NUM_STATES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  x,
  input  logic                  dir,
  input  logic                  load,
  input  logic [IW-1:0]         load_idx,
  output logic                  out,
  output logic [NUM_STATES-1:0] state_oh,
  output logic [IW-1:0]         state_idx,
  output logic                  wrap,
  output logic                  err
);

  // One extra bit so that NUM_STATES itself fits in the comparison.
  localparam int unsigned NW = IW + 1;

  logic [NUM_STATES-1:0] state_oh_q, state_oh_d;
  logic                  wrap_q, wrap_d;
  logic                  load_ok;
  logic [NUM_STATES-1:0] step_up, step_dn;

  assign load_ok = NW'(load_idx) < NW'(NUM_STATES);

  // A step is a rotation of the one-hot vector.
  assign step_up = {state_oh_q[NUM_STATES-2:0], state_oh_q[NUM_STATES-1]};
  assign step_dn = {state_oh_q[0], state_oh_q[NUM_STATES-1:1]};

`ifdef ONEHOT_RING_ERRCHK_EN
  logic err_q, err_d;
  logic legal;

  // Exactly one bit set: nonzero, and clearing the lowest set bit leaves zero.
  assign legal = (state_oh_q != '0) &&
                 ((state_oh_q & (state_oh_q - NUM_STATES'(1))) == '0);
`endif

  // Next state: illegal-state recovery (if built), then load, then x, then hold.
  always_comb begin
    state_oh_d = state_oh_q;
    wrap_d     = 1'b0;
`ifdef ONEHOT_RING_ERRCHK_EN
    err_d      = 1'b0;
    if (!legal) begin
      state_oh_d = NUM_STATES'(1);
      err_d      = 1'b1;
    end else
`endif
    if (load) begin
      if (load_ok) begin
        state_oh_d = NUM_STATES'(1) << load_idx;
      end
`ifdef ONEHOT_RING_ERRCHK_EN
      else begin
        err_d = 1'b1;
      end
`endif
    end else if (x) begin
      if (dir) begin
        state_oh_d = step_dn;
        wrap_d     = state_oh_q[0];
      end else begin
        state_oh_d = step_up;
        wrap_d     = state_oh_q[NUM_STATES-1];
      end
    end
  end

  // State and pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_oh_q <= NUM_STATES'(1);
      wrap_q     <= 1'b0;
`ifdef ONEHOT_RING_ERRCHK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_oh_q <= state_oh_d;
      wrap_q     <= wrap_d;
`ifdef ONEHOT_RING_ERRCHK_EN
      err_q      <= err_d;
`endif
    end
  end

  // One-hot to binary encoder; OR of the indices of all set bits.
  always_comb begin
    state_idx = '0;
    for (int unsigned k = 0; k < NUM_STATES; k++) begin
      if (state_oh_q[k]) begin
        state_idx = state_idx | IW'(k);
      end
    end
  end

  assign out      = |(state_oh_q & OUT_MASK);
  assign state_oh = state_oh_q;
  assign wrap     = wrap_q;
`ifdef ONEHOT_RING_ERRCHK_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_onehot_ring_fsm.sv
// Directed bench for onehot_ring_fsm. It uses three instances: the
// default 7-state ring, which gets full stimulus, and 2- and 32-state
// rings, which get full up and down laps. Expected results for the
// 7-state ring go into a queue when each step is driven. They are popped
// and compared one time unit after the clock edge.
module tb_onehot_ring_fsm;

`ifdef ONEHOT_RING_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] idx;
    logic       wrap;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, x = 1'b0, dir = 1'b0, load = 1'b0;
  logic [2:0] load_idx = '0;
  logic       out, wrap, err;
  logic [6:0] state_oh;
  logic [2:0] state_idx;

  logic        x2 = 1'b0, x32 = 1'b0;
  logic        ld_s = 1'b0;
  logic [0:0]  li2 = '0;
  logic [4:0]  li32 = '0;
  logic        out2, wrap2, err2, out32, wrap32, err32;
  logic [1:0]  oh2;
  logic [0:0]  idx2;
  logic [31:0] oh32;
  logic [4:0]  idx32;

  onehot_ring_fsm dut7 (
    .clk(clk), .rst(rst), .x(x), .dir(dir), .load(load), .load_idx(load_idx),
    .out(out), .state_oh(state_oh), .state_idx(state_idx), .wrap(wrap), .err(err)
  );

  onehot_ring_fsm #(.NUM_STATES(2)) dut2 (
    .clk(clk), .rst(rst), .x(x2), .dir(dir), .load(ld_s), .load_idx(li2),
    .out(out2), .state_oh(oh2), .state_idx(idx2), .wrap(wrap2), .err(err2)
  );

  onehot_ring_fsm #(.NUM_STATES(32)) dut32 (
    .clk(clk), .rst(rst), .x(x32), .dir(dir), .load(ld_s), .load_idx(li32),
    .out(out32), .state_oh(oh32), .state_idx(idx32), .wrap(wrap32), .err(err32)
  );

  int   checks = 0;
  int   errors = 0;
  int   m_idx  = 0;
  exp_t sb_q[$];

  function automatic void chk(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endfunction

  // Pop one expected entry and compare every output of the 7-state ring.
  task automatic check_out();
    exp_t       e;
    logic [6:0] exp_oh;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'(1), 32'(0));
      return;
    end
    e      = sb_q.pop_front();
    exp_oh = 7'(1) << e.idx;
    chk("state_idx", 32'(state_idx), 32'(e.idx));
    chk("state_oh",  32'(state_oh),  32'(exp_oh));
    chk("out",       32'(out),       32'((e.idx == 3'd0) || (e.idx == 3'd6)));
    chk("wrap",      32'(wrap),      32'(e.wrap));
    chk("err",       32'(err),       32'(e.err));
  endtask

  // Drive one cycle of inputs, predict the result, wait one edge, compare.
  task automatic step(input logic r, input logic ld, input logic xx,
                      input logic d, input logic [2:0] li, input bit bad);
    exp_t e;
    rst = r; load = ld; x = xx; dir = d; load_idx = li;
    e.wrap = 1'b0;
    e.err  = 1'b0;
    if (r) begin
      m_idx = 0;
    end else if (bad && ERRCHK) begin
      m_idx = 0;
      e.err = 1'b1;
    end else if (ld) begin
      if (int'(li) < 7) m_idx = int'(li);
      else              e.err = ERRCHK;
    end else if (xx) begin
      if (!d) begin
        e.wrap = (m_idx == 6);
        m_idx  = (m_idx + 1) % 7;
      end else begin
        e.wrap = (m_idx == 0);
        m_idx  = (m_idx + 6) % 7;
      end
    end
    e.idx = 3'(m_idx);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  // One full lap of the 2- or 32-state ring; expect exactly one wrap.
  task automatic ring_check(input int n, input logic d);
    int wraps = 0;
    int exp_i = 0;
    if (n == 2) x2 = 1'b1;
    else        x32 = 1'b1;
    for (int k = 0; k < n; k++) begin
      step(1'b0, 1'b0, 1'b0, d, 3'd0, 1'b0);
      exp_i = d ? (exp_i + n - 1) % n : (exp_i + 1) % n;
      if (n == 2) begin
        chk("ring2_idx", 32'(idx2), 32'(exp_i));
        wraps += int'(wrap2);
      end else begin
        chk("ring32_idx", 32'(idx32), 32'(exp_i));
        wraps += int'(wrap32);
      end
    end
    x2  = 1'b0;
    x32 = 1'b0;
    chk(n == 2 ? "ring2_wraps" : "ring32_wraps", 32'(wraps), 32'(1));
  endtask

  initial begin
    // Reset
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("rst_idx2",  32'(idx2),  32'(0));
    chk("rst_idx32", 32'(idx32), 32'(0));

    // Full up-lap 0..6,0 with one wrap after 6->0
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);

    // Down from 0: 6 (wrap), then 5
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0);

    // Load wins over x; out-of-range load holds
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 3'd5, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 3'd7, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

    // Hold at index 3 for 10 cycles
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

    // Reset overrides load and x at index 4
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0);

    // Reset at index 6 while stepping up: no wrap
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'd6, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);

    // Load 6 -> 0 with x=1: a load never wraps
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'd6, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);

`ifdef ONEHOT_RING_ERRCHK_EN
    // Illegal two-hot register recovers to 0 ahead of x
    force dut7.state_oh_q = 7'b0000110;
    #1;
    release dut7.state_oh_q;
    step(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
`endif

    // Small and large rings, one lap each way
    ring_check(2, 1'b0);
    ring_check(2, 1'b1);
    ring_check(32, 1'b0);
    ring_check(32, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
